// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding and the PC legality test used on every fetch start.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK  = 32'h0000_0003;

  // A fetch PC is illegal if it is not word aligned or its last byte lies outside memory.
  function automatic logic pc_bad(input logic [31:0] p, input logic [31:0] mem_bytes);
    return ((p & ALIGN_MASK) != 32'h0) || (p > (mem_bytes - 32'(INSTR_BYTES)));
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_byte_assembler.sv
// Collects the four little-endian bytes of one instruction, one byte per cycle,
// arriving one cycle after each read strobe.
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  count;
  logic        pending;
  logic [23:0] merge;

  // Track which reads are awaiting data and shift captured bytes in from the top.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count   <= 2'd0;
      pending <= 1'b0;
      merge   <= 24'h0;
    end else begin
      pending <= load;
      if (pending) begin
        merge <= {byte_in, merge[23:8]};
        count <= count + 2'd1;
      end else begin
        merge <= merge;
        count <= count;
      end
    end
  end

  // After three captures merge holds {b2,b1,b0}; the fourth byte arrives on byte_in.
  assign word      = {byte_in, merge};
  assign word_done = pending && (count == 2'd3);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads four bytes per instruction and
// hands the assembled word to decode, with redirect, fault and end-of-memory handling.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 32,
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       pc,
  output logic              done,
  output logic              fault
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [1:0]  issue_cnt;
  logic        redirect_take;
  logic        handshake;
  logic [31:0] pc_next4;
  logic        start_fetch;
  logic [31:0] start_pc;
  logic        start_bad;
  logic [31:0] asm_word;
  logic        asm_done;

  assign redirect_take = redirect_valid && ((state == FETCH) || (state == VALID) || (state == DONE));
  assign handshake     = instr_valid && instr_ready;
  assign pc_next4      = pc + 32'd4;

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .load      (mem_rd_en),
    .clear     (redirect_take),
    .byte_in   (mem_rdata),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // Decide whether a new fetch starts next cycle and from which PC.
  always_comb begin
    start_fetch = 1'b0;
    start_pc    = pc;
    case (state)
      IDLE: begin
        if (enable) start_fetch = 1'b1;
        else        start_fetch = 1'b0;
      end
      FETCH, DONE: begin
        if (redirect_take) begin
          start_fetch = 1'b1;
          start_pc    = redirect_pc;
        end else begin
          start_fetch = 1'b0;
        end
      end
      VALID: begin
        if (redirect_take) begin
          start_fetch = 1'b1;
          start_pc    = redirect_pc;
        end else if (handshake && (pc_next4 != MEM_LIMIT) && enable) begin
          start_fetch = 1'b1;
          start_pc    = pc_next4;
        end else begin
          start_fetch = 1'b0;
        end
      end
      default: start_fetch = 1'b0;
    endcase
    start_bad = pc_bad(start_pc, MEM_LIMIT);
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      issue_cnt   <= 2'd0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else if (start_fetch) begin
      // Any fetch start (including a redirect) drops a presented word and clears done.
      pc          <= start_pc;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      issue_cnt   <= 2'd0;
      if (start_bad) begin
        state     <= FAULT;
        fault     <= 1'b1;
        mem_rd_en <= 1'b0;
      end else begin
        state     <= FETCH;
        mem_rd_en <= 1'b1;
        mem_addr  <= start_pc[ADDR_W-1:0];
      end
    end else begin
      case (state)
        FETCH: begin
          if (issue_cnt != 2'd3) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + 2'd1;
          end else begin
            mem_rd_en <= 1'b0;
          end
          if (asm_done) begin
            state       <= VALID;
            instr_valid <= 1'b1;
            instr       <= asm_word;
            instr_pc    <= pc;
          end
        end
        VALID: begin
          // A handshake that continues fetching is covered by start_fetch above.
          if (handshake) begin
            instr_valid <= 1'b0;
            if (pc_next4 == MEM_LIMIT) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
              pc    <= pc_next4;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-count based reference model of the fetch sequencer.
module tb_imem_fetch_ctrl;

  localparam int M_IDLE = 0, M_FETCH = 1, M_VALID = 2, M_DONE = 3, M_FAULT = 4;

  logic        clk = 1'b0;
  logic        reset, enable, mem_rd_en, instr_valid, instr_ready, redirect_valid, done, fault;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr, instr_pc, redirect_pc, pc;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.MEM_BYTES(32), .ADDR_W(5), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .done(done), .fault(fault)
  );

  logic [7:0]  mem [32];
  logic [31:0] words [8] = '{32'h00940333, 32'h413903b3, 32'h00a50533, 32'hfff28293,
                             32'h019c1eb3, 32'h00000013, 32'h0062a023, 32'hdeadbeef};

  // Byte memory with one-cycle read latency; garbage on idle cycles exposes stray captures.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Reference model state (state of the upcoming cycle) and this cycle's expectations.
  int          m_mode = M_IDLE, m_cnt = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_done = 1'b0, m_fault = 1'b0, m_known = 1'b0, m_after_rst = 1'b0;
  logic        cur_known = 1'b0, cur_valid, cur_rd, cur_done, cur_fault, cur_after_rst;
  logic [4:0]  cur_addr;
  logic [31:0] cur_pc;
  logic [63:0] exp_q [$];
  logic        finish_req = 1'b0;
  int          n_chk = 0, n_pass = 0;

  task automatic go_fetch();
    if ((m_pc % 4) != 0 || m_pc > 32'd28) begin
      m_mode  = M_FAULT;
      m_fault = 1'b1;
    end else begin
      m_mode = M_FETCH;
      m_cnt  = 0;
    end
  endtask

  task automatic model_step(input logic en, input logic rdy, input logic rv,
                            input logic [31:0] rpc, input logic rst);
    cur_known     = m_known;
    cur_valid     = (m_mode == M_VALID);
    cur_rd        = (m_mode == M_FETCH) && (m_cnt < 4);
    cur_addr      = 5'(m_pc + 32'(m_cnt));
    cur_pc        = m_pc;
    cur_done      = m_done;
    cur_fault     = m_fault;
    cur_after_rst = m_after_rst;
    m_after_rst   = rst;
    if (m_known && m_mode == M_VALID && rdy) exp_q.push_back({m_pc, word_at(m_pc)});
    if (rst) begin
      m_mode = M_IDLE; m_pc = 32'h0; m_done = 1'b0; m_fault = 1'b0; m_cnt = 0; m_known = 1'b1;
    end else if (rv && (m_mode == M_FETCH || m_mode == M_VALID || m_mode == M_DONE)) begin
      m_done = 1'b0;
      m_pc   = rpc;
      go_fetch();
    end else begin
      case (m_mode)
        M_IDLE:  if (en) go_fetch();
        M_FETCH: if (m_cnt == 4) m_mode = M_VALID; else m_cnt++;
        M_VALID: if (rdy) begin
          if (m_pc + 32'd4 == 32'd32) begin
            m_mode = M_DONE;
            m_done = 1'b1;
          end else begin
            m_pc = m_pc + 32'd4;
            if (en) go_fetch(); else m_mode = M_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs (just after the rising edge) and advance the model.
  task automatic step(input logic en, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic rst);
    reset = rst; enable = en; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    model_step(en, rdy, rv, rpc, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares outputs mid-cycle and pops the scoreboard on every handshake.
  initial begin
    logic        stall_prev = 1'b0;
    logic [31:0] held_instr = 32'h0, held_pc = 32'h0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end else if (cur_known) begin
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, cur_valid});
        chk("mem_rd_en", {31'h0, mem_rd_en}, {31'h0, cur_rd});
        if (cur_rd) chk("mem_addr", {27'h0, mem_addr}, {27'h0, cur_addr});
        chk("pc", pc, cur_pc);
        chk("done", {31'h0, done}, {31'h0, cur_done});
        chk("fault", {31'h0, fault}, {31'h0, cur_fault});
        if (cur_after_rst) begin
          chk("rst_instr", instr, 32'h0);
          chk("rst_instr_pc", instr_pc, 32'h0);
          chk("rst_mem_addr", {27'h0, mem_addr}, 32'h0);
        end
        if (stall_prev && instr_valid) begin
          chk("hold_instr", instr, held_instr);
          chk("hold_instr_pc", instr_pc, held_pc);
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_handshake", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("hs_instr", instr, e[31:0]);
            chk("hs_instr_pc", instr_pc, e[63:32]);
          end
        end
        stall_prev = instr_valid && !instr_ready;
        held_instr = instr;
        held_pc    = instr_pc;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = words[i/4][8*(i%4) +: 8];
    reset = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    // Straight run through all eight words to done, then idle in DONE.
    for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 0);
    // Decode stall for ten cycles, then accept with enable low.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin if (m_mode == M_VALID) break; step(1, 1, 0, 0, 0); end
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    // Redirect to 16 during the second byte read of pc 4.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      if (m_mode == M_FETCH && m_pc == 32'd4 && m_cnt == 1) break;
      step(1, 1, 0, 0, 0);
    end
    step(1, 1, 1, 32'd16, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
    // Misaligned and out-of-range redirects; fault is sticky and ignores redirects.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin if (m_mode == M_FETCH) break; step(1, 1, 0, 0, 0); end
    step(1, 1, 1, 32'd6, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'd0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin if (m_mode == M_FETCH) break; step(1, 1, 0, 0, 0); end
    step(1, 1, 1, 32'd32, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    // Reset in the middle of a fetch, after the third byte read has gone out.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin if (m_mode == M_FETCH && m_cnt == 3) break; step(1, 1, 0, 0, 0); end
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    // Redirect coinciding with a handshake.
    for (int i = 0; i < 20; i++) begin if (m_mode == M_VALID) break; step(1, 1, 0, 0, 0); end
    step(1, 1, 1, 32'd12, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        en, rdy, rv, rst;
      logic [31:0] rpc;
      int          sel;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 29) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       rpc = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      else if (sel == 7) rpc = 32'($urandom_range(0, 31));
      else if (sel == 8) rpc = 32'd32;
      else               rpc = $urandom();
      if (m_mode == M_DONE || m_mode == M_FAULT) rst = ($urandom_range(0, 9) == 0);
      else                                       rst = ($urandom_range(0, 199) == 0);
      step(en, rdy, rv, rpc, rst);
    end
    cur_known  = 1'b0;
    finish_req = 1'b1;
  end

endmodule
